// File: rtl/uart_pkg.sv
// uart_pkg: constants and RX state encoding shared by uart_tx and uart_rx.
// Parity selection values match the transmitter's parity_type input.
package uart_pkg;

    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_ODD  = 2'd1;
    localparam logic [1:0] PARITY_EVEN = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } rx_state_t;

    // Encoding 3 is reserved and behaves like PARITY_NONE.
    function automatic logic parity_enabled(input logic [1:0] pt);
        return (pt == PARITY_ODD) || (pt == PARITY_EVEN);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous RX pin.
// Both flops reset to RESET_VALUE so an idle line never looks like a start bit.
module uart_rx_sync #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1/8O1/8E1 receiver, LSB first, mid-bit sampling.
// Reports every completed frame with parity and framing status.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT  = 434,
    parameter int DATA_BITS       = 8,
    parameter int CLOCK_CTR_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_data_in,
    input  logic [1:0]           parity_type,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 data_valid,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int CW    = CLOCK_CTR_WIDTH;
    localparam int IDX_W = $clog2(DATA_BITS) + 1;

    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]    C_LAST   = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0]    H_LAST   = CW'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic rx_s;

    rx_state_t            state, state_d;
    logic [CW-1:0]        cnt, cnt_d;
    logic [IDX_W-1:0]     idx, idx_d;
    logic [DATA_BITS-1:0] shreg, shreg_d;
    logic                 acc, acc_d;
    logic [1:0]           ptype, ptype_d;
    logic                 perr, perr_d;

    logic [DATA_BITS-1:0] out_data_d;
    logic                 data_valid_d;
    logic                 parity_error_d;
    logic                 frame_error_d;
    logic                 busy_d;

    uart_rx_sync #(
        .RESET_VALUE(1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (serial_data_in),
        .q   (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            shreg        <= '0;
            acc          <= 1'b0;
            ptype        <= PARITY_NONE;
            perr         <= 1'b0;
            out_data     <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            idx          <= idx_d;
            shreg        <= shreg_d;
            acc          <= acc_d;
            ptype        <= ptype_d;
            perr         <= perr_d;
            out_data     <= out_data_d;
            data_valid   <= data_valid_d;
            parity_error <= parity_error_d;
            frame_error  <= frame_error_d;
            busy         <= busy_d;
        end
    end

    always_comb begin
        state_d        = state;
        cnt_d          = cnt + CNT_ONE;
        idx_d          = idx;
        shreg_d        = shreg;
        acc_d          = acc;
        ptype_d        = ptype;
        perr_d         = perr;
        out_data_d     = out_data;
        data_valid_d   = 1'b0;
        parity_error_d = parity_error;
        frame_error_d  = frame_error;

        unique case (state)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s) begin
                    state_d = START;
                    ptype_d = parity_type;
                    acc_d   = 1'b0;
                    perr_d  = 1'b0;
                end
            end
            START: begin
                if (cnt == H_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == C_LAST) begin
                    cnt_d   = '0;
                    shreg_d = DATA_BITS'({rx_s, shreg} >> 1);
                    acc_d   = acc ^ rx_s;
                    if (idx == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = parity_enabled(ptype) ? PARITY : STOP;
                    end else begin
                        idx_d = idx + IDX_ONE;
                    end
                end
            end
            PARITY: begin
                if (cnt == C_LAST) begin
                    cnt_d   = '0;
                    // acc ^ bit is the parity of the ones count
                    perr_d  = (acc ^ rx_s) != (ptype == PARITY_ODD);
                    state_d = STOP;
                end
            end
            STOP: begin
                if (cnt == C_LAST) begin
                    cnt_d          = '0;
                    out_data_d     = shreg;
                    parity_error_d = perr;
                    frame_error_d  = !rx_s;
                    data_valid_d   = 1'b1;
                    state_d        = rx_s ? IDLE : BREAK_WAIT;
                end
            end
            BREAK_WAIT: begin
                // a held-low line must rise before another start is accepted
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule
